// File: rtl/crossbar_pkg.sv
// Shared definitions for the N-master x M-slave round-robin crossbar:
// arbiter state encoding and the width helper used for select/grant fields.
package crossbar_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Bits needed to index 'value' items; never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Per-slave round-robin arbiter: IDLE/BUSY FSM with a registered grant and pointer.
// Optional BUSY watchdog is built only when CROSSBAR_WDOG_EN is defined.
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N_MASTERS   = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int GW         = clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [N_MASTERS-1:0] i_m_req,
  input  logic                 i_s_ack,
  output logic                 o_busy,
  output logic [GW-1:0]        o_grant,
  output logic                 o_timeout
);

  localparam logic [GW:0] NM_W = (GW + 1)'(N_MASTERS);

  arb_state_t           r_state;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        r_ptr;
  logic [N_MASTERS-1:0] w_rot;
  logic [GW-1:0]        w_off;
  logic [GW:0]          w_sum;
  logic [GW-1:0]        w_pick;
  logic [GW-1:0]        w_next_ptr;
  logic                 w_found;
  logic                 w_exit;

  // Rotate so bit 0 is the master at the pointer; first set bit wins.
  assign w_rot = N_MASTERS'({i_req, i_req} >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = GW'(k);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_pick     = (w_sum >= NM_W) ? GW'(w_sum - NM_W) : GW'(w_sum);
  assign w_next_ptr = (r_grant == GW'(N_MASTERS - 1)) ? '0 : r_grant + GW'(1);
  assign w_exit     = i_s_ack | ~i_m_req[r_grant] | o_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: if (w_found) begin
          r_grant <= w_pick;
          r_state <= ARB_BUSY;
        end
        ARB_BUSY: if (w_exit) begin
          r_ptr   <= w_next_ptr;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef CROSSBAR_WDOG_EN
  localparam int CW = clog2(TIMEOUT_CYC);
  logic [CW-1:0] r_cnt;

  // Counts completed BUSY cycles; the TIMEOUT_CYC-th BUSY cycle aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (r_state == ARB_IDLE) r_cnt <= '0;
    else                          r_cnt <= r_cnt + CW'(1);
  end

  assign o_timeout = (r_state == ARB_BUSY) && (r_cnt == CW'(TIMEOUT_CYC - 1)) && !i_s_ack;
`else
  // The limit is at least 2, so this is constant low and BUSY waits indefinitely.
  assign o_timeout = (TIMEOUT_CYC < 0);
`endif

  assign o_busy  = (r_state == ARB_BUSY);
  assign o_grant = r_grant;

endmodule

// File: rtl/crossbar_nm_rr.sv
// N-master x M-slave crossbar with one round-robin arbiter per slave.
// Define CROSSBAR_WDOG_EN to enable the per-slave BUSY watchdog and m_err.
module crossbar_nm_rr
  import crossbar_pkg::*;
#(
  parameter int N_MASTERS   = 4,
  parameter int N_SLAVES    = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [N_SLAVES-1:0]           s_req,
  output logic [N_SLAVES-1:0]           s_cmd,
  output logic [N_SLAVES*ADDR_W-1:0]    s_addr,
  output logic [N_SLAVES*DATA_W-1:0]    s_wdata,
  input  logic [N_SLAVES-1:0]           s_ack,
  input  logic [N_SLAVES*DATA_W-1:0]    s_rdata
);

  localparam int SEL_W = clog2(N_SLAVES);
  localparam int GW    = clog2(N_MASTERS);

  logic [ADDR_W-1:0]    w_maddr  [N_MASTERS];
  logic [DATA_W-1:0]    w_mwdata [N_MASTERS];
  logic [SEL_W-1:0]     w_tgt    [N_MASTERS];
  logic [DATA_W-1:0]    w_srdata [N_SLAVES];
  logic [GW-1:0]        w_grant  [N_SLAVES];
  logic [N_MASTERS-1:0] w_sel    [N_SLAVES];
  logic [N_SLAVES-1:0]  w_busy;
  logic [N_SLAVES-1:0]  w_tout;

  for (genvar m = 0; m < N_MASTERS; m++) begin : g_mdec
    assign w_maddr[m]  = m_addr[m*ADDR_W +: ADDR_W];
    assign w_mwdata[m] = m_wdata[m*DATA_W +: DATA_W];
    assign w_tgt[m]    = w_maddr[m][ADDR_W-1 -: SEL_W];
  end

  for (genvar s = 0; s < N_SLAVES; s++) begin : g_slv
    logic [N_MASTERS-1:0] w_req_s;

    for (genvar m = 0; m < N_MASTERS; m++) begin : g_req
      assign w_req_s[m] = m_req[m] && (w_tgt[m] == SEL_W'(s));
    end

    // Abort watches the raw request so a retargeted address keeps the grant.
    rr_arbiter #(
      .N_MASTERS  (N_MASTERS),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (w_req_s),
      .i_m_req  (m_req),
      .i_s_ack  (s_ack[s]),
      .o_busy   (w_busy[s]),
      .o_grant  (w_grant[s]),
      .o_timeout(w_tout[s])
    );

    assign w_sel[s]    = w_busy[s] ? (N_MASTERS'(1) << w_grant[s]) : '0;
    assign w_srdata[s] = s_rdata[s*DATA_W +: DATA_W];
    assign s_req[s]    = w_busy[s] & ~w_tout[s];
    assign s_cmd[s]    = w_busy[s] & m_cmd[w_grant[s]];
    assign s_addr[s*ADDR_W +: ADDR_W]  = w_busy[s] ? w_maddr[w_grant[s]]  : '0;
    assign s_wdata[s*DATA_W +: DATA_W] = w_busy[s] ? w_mwdata[w_grant[s]] : '0;
  end

  for (genvar m = 0; m < N_MASTERS; m++) begin : g_mret
    logic              w_ack_m;
    logic [DATA_W-1:0] w_rd_m;

    always_comb begin
      w_ack_m = 1'b0;
      w_rd_m  = '0;
      for (int s = 0; s < N_SLAVES; s++) begin
        if (w_sel[s][m]) begin
          w_ack_m = w_ack_m | s_ack[s] | w_tout[s];
          w_rd_m  = w_rd_m | w_srdata[s];
        end
      end
    end

    assign m_ack[m]                    = w_ack_m;
    assign m_rdata[m*DATA_W +: DATA_W] = w_rd_m;

`ifdef CROSSBAR_WDOG_EN
    logic w_err_m;

    always_comb begin
      w_err_m = 1'b0;
      for (int s = 0; s < N_SLAVES; s++) begin
        if (w_sel[s][m]) w_err_m = w_err_m | w_tout[s];
      end
    end

    assign m_err[m] = w_err_m;
`else
    assign m_err[m] = 1'b0;
`endif
  end

endmodule

// File: doc/crossbar_nm_rr.md
CROSSBAR_NM_RR -- requirements
Module: crossbar_nm_rr

Interface
REQ-001 Parameter N_MASTERS, 4, number of master ports, range 2..8.
REQ-002 Parameter N_SLAVES, 4, number of slave ports, power of two, range 2..8.
REQ-003 Parameter ADDR_W, 32, address width.
REQ-004 Parameter DATA_W, 32, wdata/rdata width.
REQ-005 Parameter TIMEOUT_CYC, 16, watchdog limit in cycles, used only with the watchdog macro, range 2..255.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 Port list SHALL be as follows, with per-port buses packed and port 0 in the LSBs:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- m_req  in  N_MASTERS  master request, held until ack
- m_cmd  in  N_MASTERS  1=write, 0=read
- m_addr  in  N_MASTERS*ADDR_W  master address
- m_wdata  in  N_MASTERS*DATA_W  master write data
- m_ack  out  N_MASTERS  transfer complete
- m_rdata  out  N_MASTERS*DATA_W  read data
- m_err  out  N_MASTERS  watchdog abort, valid with m_ack
- s_req  out  N_SLAVES  slave request
- s_cmd  out  N_SLAVES  slave command
- s_addr  out  N_SLAVES*ADDR_W  slave address
- s_wdata  out  N_SLAVES*DATA_W  slave write data
- s_ack  in  N_SLAVES  slave complete
- s_rdata  in  N_SLAVES*DATA_W  slave read data

Function
REQ-008 Target slave SHALL be addr[ADDR_W-1 -: SEL_W], where SEL_W = log2(N_SLAVES).
REQ-009 Each slave SHALL have an independent arbiter FSM with states IDLE and BUSY, a registered grant index, and a round-robin pointer.
REQ-010 IDLE: when one or more masters request this slave, the arbiter SHALL grant the first requester at or after the pointer (wrapping), register the grant, and go to BUSY at the next edge; this is 1-cycle request-to-s_req latency.
REQ-011 BUSY: s_req/s_cmd/s_addr/s_wdata SHALL combinationally mirror the granted master; s_ack and s_rdata SHALL combinationally route to that master's m_ack and m_rdata in the same cycle.
REQ-012 A slave in BUSY SHALL exit to IDLE on s_ack, or when the granted master drops m_req (abort); on either exit the pointer SHALL become grant+1 mod N_MASTERS.
REQ-013 Grants SHALL be held: no other master is granted the slave while BUSY, whatever the request pattern.
REQ-014 A slave SHALL have a one-cycle IDLE bubble between consecutive grants.
REQ-015 Ungranted s_* outputs and unrouted m_ack/m_rdata/m_err SHALL be 0.
REQ-016 Simultaneous grants to different slaves SHALL proceed in parallel with no interaction.
REQ-017 A master changing its m_addr slave field while granted SHALL NOT move the grant; the transfer completes on the original slave.

Reset
REQ-018 While rst_n=0, every FSM SHALL be IDLE, every pointer 0, and every grant invalid, so all outputs are 0.
REQ-019 Reset asserted mid-transfer SHALL drop s_req/m_ack asynchronously; after release, arbitration restarts from IDLE.

Configuration
REQ-020 With CROSSBAR_WDOG_EN defined, each slave SHALL have a BUSY cycle counter; if it reaches TIMEOUT_CYC without s_ack, the arbiter SHALL pulse m_ack=1 and m_err=1 to the granted master for one cycle, drop s_req, go to IDLE, and advance the pointer.
REQ-021 Without CROSSBAR_WDOG_EN, no counter SHALL exist, m_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Structure
REQ-022 Package crossbar_pkg SHALL hold the IDLE/BUSY state encoding and the clog2 helper used for SEL_W and the grant index width.
REQ-023 Sub-module rr_arbiter (FSM, pointer, grant, optional watchdog) SHALL be instantiated N_SLAVES times; muxing and decode stay in the top.

Verification
REQ-024 Single master: M0 reads addr 0x4000_0010 -> S1 s_req at cycle+1; s_ack with rdata 0xDEAD_BEEF -> m_ack[0]=1 and m_rdata[0]=0xDEAD_BEEF in the same cycle.
REQ-025 Contention: M0..M3 all hold requests to S0 with the pointer at 0, each s_ack after 2 cycles -> grant order 0,1,2,3,0, with one IDLE bubble between grants.
REQ-026 Parallel: M0 targets S0 (0x0...) and M2 targets S3 (0xC...) simultaneously -> both s_req rise in the same cycle; the other outputs stay 0.
REQ-027 Abort: M1 granted on S2 drops m_req before s_ack -> S2 is IDLE next edge, pointer=2, s_req[2]=0.
REQ-028 Reset: rst_n low during BUSY -> all outputs 0 immediately; after release, a pending M3 request is granted one cycle later.
REQ-029 With CROSSBAR_WDOG_EN and TIMEOUT_CYC=16, S1 never acks -> m_ack=m_err=1 for one cycle at BUSY cycle 16, then S1 is IDLE.
